fetch_decode_frontend: RTL and testbench

- In-order front end of the Tomasulo core: fetches one 32-bit AArch64 instruction per cycle from a local instruction memory and decodes it into a registered dispatch bundle for the register/rename stage.
- Two stages: F register (raw instruction + PC), then D register (decoded fields).
- Predicts not-taken; ROB mispredict redirects the PC and flushes both stages.

---
 rtl/fetch_decode_frontend.sv | 211 +++++++++++++++++++++
 tb/tb_fetch_decode_frontend.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_frontend.sv
// Two-stage in-order front end: F holds the raw word + PC, D holds the decoded dispatch bundle.
// Predict-not-taken; a ROB mispredict redirects the PC and flushes both stages.
module fetch_decode_frontend #(
  parameter int          IMEM_WORDS = 1024,
  parameter logic [63:0] RESET_PC   = 64'd0
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic                          in_imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] in_imem_addr,
  input  logic [31:0]                   in_imem_data,
  input  logic                          in_stall,
  input  logic                          in_rob_mispredict,
  input  logic [63:0]                   in_rob_new_PC,
  output logic                          out_valid,
  output logic [63:0]                   out_pc,
  output logic [4:0]                    out_op,
  output logic [4:0]                    out_rd,
  output logic [4:0]                    out_rn,
  output logic [4:0]                    out_rm,
  output logic                          out_rd_we,
  output logic                          out_rn_valid,
  output logic                          out_rm_valid,
  output logic [63:0]                   out_imm,
  output logic [3:0]                    out_cond,
  output logic                          out_set_nzcv,
  output logic                          out_use_nzcv,
  output logic                          out_halt
);
  localparam int AW = $clog2(IMEM_WORDS);

  typedef enum logic [4:0] {
    OP_NOP = 5'd0, OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ORR, OP_EOR, OP_MOVZ,
    OP_LDUR, OP_STUR, OP_B, OP_BCOND, OP_CBZ, OP_CBNZ, OP_RET, OP_HLT, OP_ERR
  } op_e;

  typedef struct packed {
    logic [63:0] pc;
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic        rd_we;
    logic        rn_valid;
    logic        rm_valid;
    logic [63:0] imm;
    logic [3:0]  cond;
    logic        set_nzcv;
    logic        use_nzcv;
  } dec_t;

  logic [31:0]   r_imem [IMEM_WORDS];
  logic [63:0]   r_pc;
  logic          r_halt;
  logic          r_f_vld;
  logic [31:0]   r_f_ins;
  logic [63:0]   r_f_pc;
  logic          r_d_vld;
  dec_t          r_d;

  logic [AW-1:0] w_fetch_idx;
  logic [31:0]   w_fetch_word;
  logic          w_fetch_hlt;
  logic [31:0]   w_ins;
  dec_t          w_dec;

  function automatic op_e arith_op(input logic [1:0] sub_s);
    case (sub_s)
      2'b00:   return OP_ADD;
      2'b01:   return OP_ADDS;
      2'b10:   return OP_SUB;
      default: return OP_SUBS;
    endcase
  endfunction

  function automatic op_e logic_op(input logic [1:0] sel);
    case (sel)
      2'b00:   return OP_AND;
      2'b01:   return OP_ORR;
      default: return OP_EOR;
    endcase
  endfunction

  always_ff @(posedge in_clk) begin
    if (in_imem_we) r_imem[in_imem_addr] <= in_imem_data;
  end

  assign w_fetch_idx  = AW'(r_pc[63:2] % 62'(IMEM_WORDS));
  assign w_fetch_word = r_imem[w_fetch_idx];
  assign w_fetch_hlt  = (w_fetch_word[31:21] == 11'b11010100010);
  assign w_ins        = r_f_ins;

  always_comb begin
    w_dec    = '0;
    w_dec.pc = r_f_pc;
    w_dec.op = OP_ERR;
    if (w_ins == 32'hD65F03C0) begin
      w_dec.op       = OP_RET;
      w_dec.rn       = 5'd30;
      w_dec.rn_valid = 1'b1;
    end else if (w_ins == 32'hD503201F) begin
      w_dec.op = OP_NOP;
    end else if (w_ins[31] && w_ins[28:23] == 6'b100010) begin
      w_dec.op       = arith_op(w_ins[30:29]);
      w_dec.rd       = w_ins[4:0];
      w_dec.rn       = w_ins[9:5];
      w_dec.rd_we    = 1'b1;
      w_dec.rn_valid = 1'b1;
      w_dec.imm      = {52'd0, w_ins[21:10]};
      w_dec.set_nzcv = w_ins[29];
    end else if (w_ins[31] && w_ins[28:21] == 8'b01011000) begin
      w_dec.op       = arith_op(w_ins[30:29]);
      w_dec.rd       = w_ins[4:0];
      w_dec.rn       = w_ins[9:5];
      w_dec.rm       = w_ins[20:16];
      w_dec.rd_we    = 1'b1;
      w_dec.rn_valid = 1'b1;
      w_dec.rm_valid = 1'b1;
      w_dec.set_nzcv = w_ins[29];
    end else if (w_ins[31] && w_ins[28:21] == 8'b01010000 && w_ins[30:29] != 2'b11) begin
      w_dec.op       = logic_op(w_ins[30:29]);
      w_dec.rd       = w_ins[4:0];
      w_dec.rn       = w_ins[9:5];
      w_dec.rm       = w_ins[20:16];
      w_dec.rd_we    = 1'b1;
      w_dec.rn_valid = 1'b1;
      w_dec.rm_valid = 1'b1;
    end else if (w_ins[31:21] == 11'b11111000010) begin
      w_dec.op       = OP_LDUR;
      w_dec.rd       = w_ins[4:0];
      w_dec.rn       = w_ins[9:5];
      w_dec.rd_we    = 1'b1;
      w_dec.rn_valid = 1'b1;
      w_dec.imm      = {{55{w_ins[20]}}, w_ins[20:12]};
    end else if (w_ins[31:21] == 11'b11111000000) begin
      // store data register travels on the rm port
      w_dec.op       = OP_STUR;
      w_dec.rm       = w_ins[4:0];
      w_dec.rn       = w_ins[9:5];
      w_dec.rn_valid = 1'b1;
      w_dec.rm_valid = 1'b1;
      w_dec.imm      = {{55{w_ins[20]}}, w_ins[20:12]};
    end else if (w_ins[31:23] == 9'b110100101) begin
      w_dec.op    = OP_MOVZ;
      w_dec.rd    = w_ins[4:0];
      w_dec.rd_we = 1'b1;
      w_dec.imm   = 64'(w_ins[20:5]) << {w_ins[22:21], 4'b0000};
    end else if (w_ins[31:26] == 6'b000101) begin
      w_dec.op  = OP_B;
      w_dec.imm = {{36{w_ins[25]}}, w_ins[25:0], 2'b00};
    end else if (w_ins[31:24] == 8'b01010100) begin
      w_dec.op       = OP_BCOND;
      w_dec.imm      = {{43{w_ins[23]}}, w_ins[23:5], 2'b00};
      w_dec.cond     = w_ins[3:0];
      w_dec.use_nzcv = 1'b1;
    end else if (w_ins[31:25] == 7'b1011010) begin
      w_dec.op       = w_ins[24] ? OP_CBNZ : OP_CBZ;
      w_dec.imm      = {{43{w_ins[23]}}, w_ins[23:5], 2'b00};
      w_dec.rm       = w_ins[4:0];
      w_dec.rm_valid = 1'b1;
    end else if (w_ins[31:21] == 11'b11010100010) begin
      w_dec.op = OP_HLT;
    end
  end

  // Mispredict outranks stall and halt; while halted F drains so no bundle repeats.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_pc    <= RESET_PC;
      r_halt  <= 1'b0;
      r_f_vld <= 1'b0;
      r_f_ins <= '0;
      r_f_pc  <= '0;
      r_d_vld <= 1'b0;
      r_d     <= '0;
    end else if (in_rob_mispredict) begin
      r_pc    <= in_rob_new_PC;
      r_halt  <= 1'b0;
      r_f_vld <= 1'b0;
      r_d_vld <= 1'b0;
    end else if (!in_stall) begin
      if (r_halt) begin
        r_f_vld <= 1'b0;
      end else begin
        r_f_vld <= 1'b1;
        r_f_ins <= w_fetch_word;
        r_f_pc  <= r_pc;
        if (w_fetch_hlt) r_halt <= 1'b1;
        else             r_pc   <= r_pc + 64'd4;
      end
      r_d_vld <= r_f_vld;
      r_d     <= w_dec;
    end
  end

  assign out_valid    = r_d_vld;
  assign out_pc       = r_d.pc;
  assign out_op       = r_d.op;
  assign out_rd       = r_d.rd;
  assign out_rn       = r_d.rn;
  assign out_rm       = r_d.rm;
  assign out_rd_we    = r_d.rd_we;
  assign out_rn_valid = r_d.rn_valid;
  assign out_rm_valid = r_d.rm_valid;
  assign out_imm      = r_d.imm;
  assign out_cond     = r_d.cond;
  assign out_set_nzcv = r_d.set_nzcv;
  assign out_use_nzcv = r_d.use_nzcv;
  assign out_halt     = r_halt;

endmodule

// File: tb/tb_fetch_decode_frontend.sv
// Bench for fetch_decode_frontend: directed plan steps, then randomized stall/redirect traffic
// scored against an architectural fetch-sequence model.
module tb_fetch_decode_frontend;
  localparam int          WORDS = 64;
  localparam logic [63:0] RPC   = 64'd0;
  localparam logic [31:0] NOP   = 32'hD503201F;
  localparam logic [31:0] HLT   = 32'hD4400000;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_imem_we;
  logic [5:0]  in_imem_addr;
  logic [31:0] in_imem_data;
  logic        in_stall;
  logic        in_rob_mispredict;
  logic [63:0] in_rob_new_PC;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [4:0]  out_op, out_rd, out_rn, out_rm;
  logic        out_rd_we, out_rn_valid, out_rm_valid;
  logic [63:0] out_imm;
  logic [3:0]  out_cond;
  logic        out_set_nzcv, out_use_nzcv, out_halt;

  fetch_decode_frontend #(.IMEM_WORDS(WORDS), .RESET_PC(RPC)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_imem_we(in_imem_we), .in_imem_addr(in_imem_addr),
    .in_imem_data(in_imem_data), .in_stall(in_stall), .in_rob_mispredict(in_rob_mispredict),
    .in_rob_new_PC(in_rob_new_PC), .out_valid(out_valid), .out_pc(out_pc), .out_op(out_op),
    .out_rd(out_rd), .out_rn(out_rn), .out_rm(out_rm), .out_rd_we(out_rd_we),
    .out_rn_valid(out_rn_valid), .out_rm_valid(out_rm_valid), .out_imm(out_imm),
    .out_cond(out_cond), .out_set_nzcv(out_set_nzcv), .out_use_nzcv(out_use_nzcv),
    .out_halt(out_halt)
  );

  always #5 in_clk = ~in_clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  op, rd, rn, rm;
    logic        rd_we, rn_v, rm_v;
    logic [63:0] imm;
    logic [3:0]  cond;
    logic        set_f, use_f;
  } bun_t;

  bun_t        exp_q[$];
  logic [31:0] mem_m [WORDS];
  logic [63:0] m_pc;
  bit          m_halt;
  int          edge_kind;   // 0 reset/none, 1 advance, 2 stall, 3 redirect
  int          n_pass = 0, n_total = 0, n_popped = 0;
  bun_t        last_out;
  logic        last_vld;

  function automatic bun_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
    bun_t        e;
    longint      s;
    logic [8:0]  t9;
    logic [10:0] t11;
    logic [7:0]  t8;
    t9 = w[31:23]; t11 = w[31:21]; t8 = w[31:24];
    e = '0; e.pc = pc; e.op = 5'd17;
    if (w == 32'hD65F03C0) begin
      e.op = 5'd15; e.rn = 5'd30; e.rn_v = 1'b1;
    end else if (w == NOP) begin
      e.op = 5'd0;
    end else begin
      case (t9)
        9'b100100010: e.op = 5'd1;
        9'b101100010: e.op = 5'd2;
        9'b110100010: e.op = 5'd3;
        9'b111100010: e.op = 5'd4;
        default: ;
      endcase
      if (e.op != 5'd17) begin
        e.rd = w[4:0]; e.rn = w[9:5]; e.rd_we = 1'b1; e.rn_v = 1'b1;
        e.imm = 64'(w[21:10]); e.set_f = (e.op == 5'd2 || e.op == 5'd4);
      end else begin
        case (t11)
          11'b10001011000: e.op = 5'd1;
          11'b10101011000: e.op = 5'd2;
          11'b11001011000: e.op = 5'd3;
          11'b11101011000: e.op = 5'd4;
          11'b10001010000: e.op = 5'd5;
          11'b10101010000: e.op = 5'd6;
          11'b11001010000: e.op = 5'd7;
          default: ;
        endcase
        if (e.op != 5'd17) begin
          e.rd = w[4:0]; e.rn = w[9:5]; e.rm = w[20:16];
          e.rd_we = 1'b1; e.rn_v = 1'b1; e.rm_v = 1'b1;
          e.set_f = (e.op == 5'd2 || e.op == 5'd4);
        end else if (t11 == 11'b11111000010 || t11 == 11'b11111000000) begin
          s = $signed(w[20:12]);
          e.imm = s; e.rn = w[9:5]; e.rn_v = 1'b1;
          if (w[22]) begin e.op = 5'd9; e.rd = w[4:0]; e.rd_we = 1'b1; end
          else begin e.op = 5'd10; e.rm = w[4:0]; e.rm_v = 1'b1; end
        end else if (t9 == 9'b110100101) begin
          e.op = 5'd8; e.rd = w[4:0]; e.rd_we = 1'b1;
          e.imm = 64'(w[20:5]) * (64'd1 << (16 * w[22:21]));
        end else if (w[31:26] == 6'b000101) begin
          s = $signed(w[25:0]); e.op = 5'd11; e.imm = s * 4;
        end else if (t8 == 8'b01010100) begin
          s = $signed(w[23:5]); e.op = 5'd12; e.imm = s * 4; e.cond = w[3:0]; e.use_f = 1'b1;
        end else if (t8 == 8'b10110100 || t8 == 8'b10110101) begin
          s = $signed(w[23:5]); e.op = (t8 == 8'b10110100) ? 5'd13 : 5'd14;
          e.imm = s * 4; e.rm = w[4:0]; e.rm_v = 1'b1;
        end else if (t11 == 11'b11010100010) begin
          e.op = 5'd16;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 39))
      0, 1, 2:    r[31:23] = {1'b1, 2'($urandom), 6'b100010};
      3, 4, 5:    r[31:21] = {1'b1, 2'($urandom), 8'b01011000};
      6, 7:       r[31:21] = {1'b1, 2'($urandom_range(0, 2)), 8'b01010000};
      8, 9, 10:   r[31:21] = 11'b11111000010;
      11, 12:     r[31:21] = 11'b11111000000;
      13, 14:     r[31:23] = 9'b110100101;
      15, 16:     r[31:26] = 6'b000101;
      17, 18:     r[31:24] = 8'b01010100;
      19, 20:     r[31:25] = 7'b1011010;
      21:         r = 32'hD65F03C0;
      22, 23:     r = NOP;
      24:         r[31:21] = 11'b11010100010;
      default: ;
    endcase
    return r;
  endfunction

  // Architectural model: each unstalled, unhalted edge fetches the next word in program order.
  always @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      exp_q.delete(); m_pc = RPC; m_halt = 0; edge_kind = 0;
    end else if (in_rob_mispredict) begin
      exp_q.delete(); m_pc = in_rob_new_PC; m_halt = 0; edge_kind = 3;
    end else if (in_stall) begin
      edge_kind = 2;
    end else begin
      logic [31:0] w;
      edge_kind = 1;
      if (!m_halt) begin
        w = mem_m[int'((m_pc >> 2) % 64'(WORDS))];
        exp_q.push_back(ref_decode(w, m_pc));
        if (w[31:21] == 11'b11010100010) m_halt = 1;
        else m_pc = m_pc + 64'd4;
      end
    end
  end

  always @(negedge in_clk) begin
    bun_t act, e;
    act = {out_pc, out_op, out_rd, out_rn, out_rm, out_rd_we, out_rn_valid, out_rm_valid,
           out_imm, out_cond, out_set_nzcv, out_use_nzcv};
    if (in_rst === 1'b1) begin
      n_total++;
      if (out_halt === m_halt) n_pass++;
      else $display("FAIL halt_flag: got %b expected %b at %0t", out_halt, m_halt, $time);
      case (edge_kind)
        1: if (out_valid === 1'b1) begin
             n_total++;
             if (exp_q.size() == 0) begin
               $display("FAIL unexpected_bundle: got pc=%h op=%0d, expected none", out_pc, out_op);
             end else begin
               e = exp_q.pop_front();
               n_popped++;
               if (act === e) n_pass++;
               else $display("FAIL bundle: got %h expected %h", act, e);
             end
           end
        2: begin
             n_total++;
             if (out_valid === last_vld && act === last_out) n_pass++;
             else $display("FAIL stall_hold: got v=%b %h expected v=%b %h", out_valid, act, last_vld, last_out);
           end
        3: begin
             n_total++;
             if (out_valid === 1'b0) n_pass++;
             else $display("FAIL flush: got valid=%b expected 0", out_valid);
           end
        default: ;
      endcase
    end
    last_out = act;
    last_vld = out_valid;
  end

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    in_imem_we = 1'b1; in_imem_addr = 6'(a); in_imem_data = d;
    mem_m[a] = d;
    step();
    in_imem_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_rst = 1'b1; in_imem_we = 1'b0; in_imem_addr = '0; in_imem_data = '0;
    in_stall = 1'b0; in_rob_mispredict = 1'b0; in_rob_new_PC = '0;
    #2 in_rst = 1'b0;
    for (int i = 0; i < WORDS; i++) wr(i, NOP);
    wr(0, 32'h91000C20);   // ADD X0,X1,#3
    wr(1, 32'hEB0700C5);   // SUBS X5,X6,X7
    wr(2, 32'hF85F8062);   // LDUR X2,[X3,#-8]
    wr(3, 32'hF80100A4);   // STUR X4,[X5,#16]
    wr(4, 32'h54000041);   // B.NE +8
    wr(16, 32'hD2A24689);  // MOVZ X9,#0x1234,LSL #16
    wr(17, 32'hD65F03C0);  // RET
    wr(18, HLT);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_op", 64'(out_op), 64'd0);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_rd_we", 64'(out_rd_we), 64'd0);
    chk("rst_halt", 64'(out_halt), 64'd0);

    in_rst = 1'b1;
    step(); chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    step(); chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_op", 64'(out_op), 64'd1); chk("add_rd", 64'(out_rd), 64'd0);
    chk("add_rn", 64'(out_rn), 64'd1); chk("add_imm", out_imm, 64'd3);
    chk("add_pc", out_pc, 64'd0); chk("add_rd_we", 64'(out_rd_we), 64'd1);
    step(); chk("subs_pc", out_pc, 64'd4); chk("subs_nzcv", 64'(out_set_nzcv), 64'd1);
    step(); chk("ldur_pc", out_pc, 64'd8); chk("ldur_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    step(); chk("stur_pc", out_pc, 64'hC); chk("stur_rm", 64'(out_rm), 64'd4);
    step(); chk("bcond_op", 64'(out_op), 64'd12); chk("bcond_cond", 64'(out_cond), 64'd1);
    chk("bcond_imm", out_imm, 64'd8); chk("bcond_use", 64'(out_use_nzcv), 64'd1);

    in_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_pc", out_pc, 64'h10); chk("stall_valid", 64'(out_valid), 64'd1);
    end
    in_stall = 1'b0;
    step(); chk("post_stall_pc", out_pc, 64'h14);

    in_rob_mispredict = 1'b1; in_rob_new_PC = 64'h40;
    step(); in_rob_mispredict = 1'b0;
    chk("redir_valid0", 64'(out_valid), 64'd0);
    step(); chk("redir_valid1", 64'(out_valid), 64'd0);
    step(); chk("redir_valid2", 64'(out_valid), 64'd1); chk("redir_pc", out_pc, 64'h40);
    chk("movz_imm", out_imm, 64'h1234_0000);
    step(); chk("ret_rn", 64'(out_rn), 64'd30);
    step(); chk("hlt_op", 64'(out_op), 64'd16); chk("hlt_flag", 64'(out_halt), 64'd1);
    step(); chk("post_hlt_valid", 64'(out_valid), 64'd0);

    wr(0, NOP); wr(1, 32'h91001462); wr(2, HLT);
    in_rob_mispredict = 1'b1; in_rob_new_PC = 64'd0;
    step(); in_rob_mispredict = 1'b0;
    chk("redir_clears_halt", 64'(out_halt), 64'd0);
    repeat (6) step();
    chk("halt_at_8", 64'(out_halt), 64'd1);
    chk("halt_last_pc", out_pc, 64'd8);
    in_rob_mispredict = 1'b1;
    step(); in_rob_mispredict = 1'b0;
    chk("refetch_halt_clear", 64'(out_halt), 64'd0);
    step(); step();
    chk("refetch_valid", 64'(out_valid), 64'd1); chk("refetch_pc", out_pc, 64'd0);
    #3 in_rst = 1'b0;
    #1 chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_halt", 64'(out_halt), 64'd0);
    step(); in_rst = 1'b1;
    step(); chk("rst2_valid0", 64'(out_valid), 64'd0);
    step(); chk("rst2_valid1", 64'(out_valid), 64'd1); chk("rst2_pc", out_pc, RPC);
    for (int i = 0; i < 20 && out_halt !== 1'b1; i++) step();
    chk("halt_before_load", 64'(out_halt), 64'd1);

    for (int i = 0; i < WORDS; i++) wr(i, rand_instr());
    in_rob_mispredict = 1'b1; in_rob_new_PC = 64'd0;
    step();
    for (int i = 0; i < 3000; i++) begin
      in_stall = ($urandom_range(0, 3) == 0);
      in_rob_mispredict = ($urandom_range(0, 29) == 0) || (out_halt && $urandom_range(0, 3) == 0);
      in_rob_new_PC = {$urandom, $urandom} & ~64'h3;
      step();
    end
    in_stall = 1'b0; in_rob_mispredict = 1'b0;
    repeat (4) step();
    chk("random_activity", 64'(n_popped >= 500), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
